wifi_reset_sequencer: RTL and testbench

- Consumes the level written by the WiFi-reset PIO (1 = release, 0 = reset request) and drives the WiFi module's active-low reset pin.
- Guarantees a minimum reset-low width and a post-release boot wait, and flags when the module can be addressed.
- Status outputs feed a PIO input / IRQ so software polls or waits on `wifi_ready` instead of using busy-wait delays.
- Sits between the PIO out_port and the top-level WiFi reset pin.

---
 rtl/wifi_reset_sequencer.sv | 117 +++++++++++
 tb/tb_wifi_reset_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/wifi_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wifi_reset_sequencer: drives the WiFi module reset pin from a PIO level,  |
// | enforcing a minimum low width and a boot wait before flagging ready.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module wifi_reset_sequencer #(
   parameter int MIN_LOW_CYCLES   = 500000,
   parameter int BOOT_WAIT_CYCLES = 25000000,
   parameter int CNT_WIDTH        = 25
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_level,
   output logic       wifi_rst_n,
   output logic       wifi_ready,
   output logic       busy,
   output logic       boot_done,
   output logic [7:0] reset_count
);

   localparam logic [CNT_WIDTH-1:0] LOW_LAST  = CNT_WIDTH'(MIN_LOW_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] BOOT_LAST = CNT_WIDTH'(BOOT_WAIT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      BOOT  = 2'd1,
      READY = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic [7:0]           count_nxt;
   logic                 boot_done_nxt;
   logic                 req_meta;
   logic                 req_s;

   // Synchroniser idles at "release" so a system reset alone does not count as a request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_meta <= 1'b1;
         req_s    <= 1'b1;
      end else begin
         req_meta <= req_level;
         req_s    <= req_meta;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= HOLD;
         cnt         <= '0;
         reset_count <= 8'd0;
         wifi_rst_n  <= 1'b0;
         wifi_ready  <= 1'b0;
         busy        <= 1'b1;
         boot_done   <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         reset_count <= count_nxt;
         wifi_rst_n  <= (state_nxt != HOLD);
         wifi_ready  <= (state_nxt == READY);
         busy        <= (state_nxt != READY);
         boot_done   <= boot_done_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      count_nxt     = reset_count;
      boot_done_nxt = 1'b0;
      case (state)
         HOLD: begin
            if (cnt == LOW_LAST) begin
               if (req_s) begin
                  state_nxt = BOOT;
                  cnt_nxt   = '0;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         BOOT: begin
            // A new request wins over completing the boot wait, even on its last cycle.
            if (!req_s) begin
               state_nxt = HOLD;
               cnt_nxt   = '0;
               if (reset_count != 8'hFF) count_nxt = reset_count + 8'd1;
            end else if (cnt == BOOT_LAST) begin
               state_nxt     = READY;
               cnt_nxt       = '0;
               boot_done_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         READY: begin
            if (!req_s) begin
               state_nxt = HOLD;
               cnt_nxt   = '0;
               if (reset_count != 8'hFF) count_nxt = reset_count + 8'd1;
            end
         end
         default: begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_wifi_reset_sequencer.sv
`default_nettype none
// Directed bench for wifi_reset_sequencer with short timing parameters.
module tb_wifi_reset_sequencer;

   logic       clk;
   logic       reset_n;
   logic       req_level;
   logic       wifi_rst_n;
   logic       wifi_ready;
   logic       busy;
   logic       boot_done;
   logic [7:0] reset_count;

   int vectors = 0;
   int errors  = 0;

   wifi_reset_sequencer #(
      .MIN_LOW_CYCLES  (4),
      .BOOT_WAIT_CYCLES(6),
      .CNT_WIDTH       (4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_level  (req_level),
      .wifi_rst_n (wifi_rst_n),
      .wifi_ready (wifi_ready),
      .busy       (busy),
      .boot_done  (boot_done),
      .reset_count(reset_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // exp packs {wifi_rst_n, wifi_ready, busy, boot_done}; one check per cycle.
   task automatic expect_run(input string tag, input int n, input logic [3:0] exp);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk(tag, {4'b0, wifi_rst_n, wifi_ready, busy, boot_done}, {4'b0, exp});
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      req_level = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_outputs", {4'b0, wifi_rst_n, wifi_ready, busy, boot_done}, 8'b0010);
      chk("rst_count", reset_count, 8'd0);

      // Power-on with req_level held high
      reset_n = 1'b1;
      expect_run("po_hold", 3, 4'b0010);
      expect_run("po_boot", 6, 4'b1010);
      expect_run("po_ready_edge", 1, 4'b1101);
      expect_run("po_ready", 2, 4'b1100);
      chk("po_count", reset_count, 8'd0);

      // One-cycle request from READY
      req_level = 1'b0;
      expect_run("r1_sync", 1, 4'b1100);
      req_level = 1'b1;
      expect_run("r1_sync2", 1, 4'b1100);
      expect_run("r1_hold", 4, 4'b0010);
      expect_run("r1_boot", 6, 4'b1010);
      expect_run("r1_ready_edge", 1, 4'b1101);
      chk("r1_count", reset_count, 8'd1);

      // Twenty-cycle request from READY
      req_level = 1'b0;
      expect_run("l20_sync", 2, 4'b1100);
      expect_run("l20_hold", 18, 4'b0010);
      req_level = 1'b1;
      expect_run("l20_hold_tail", 2, 4'b0010);
      expect_run("l20_boot", 6, 4'b1010);
      expect_run("l20_ready_edge", 1, 4'b1101);
      chk("l20_count", reset_count, 8'd2);

      // Request from READY, then an abort seen at BOOT cnt 3
      req_level = 1'b0;
      expect_run("b3_sync", 1, 4'b1100);
      req_level = 1'b1;
      expect_run("b3_sync2", 1, 4'b1100);
      expect_run("b3_hold", 4, 4'b0010);
      expect_run("b3_boot_a", 2, 4'b1010);
      req_level = 1'b0;
      expect_run("b3_boot_b", 1, 4'b1010);
      req_level = 1'b1;
      expect_run("b3_boot_c", 1, 4'b1010);
      expect_run("b3_abort_hold", 4, 4'b0010);
      chk("b3_count", reset_count, 8'd4);

      // Abort landing on the terminal BOOT cycle
      expect_run("bt_boot_a", 4, 4'b1010);
      req_level = 1'b0;
      expect_run("bt_boot_b", 1, 4'b1010);
      req_level = 1'b1;
      expect_run("bt_boot_c", 1, 4'b1010);
      expect_run("bt_abort_hold", 4, 4'b0010);
      chk("bt_count", reset_count, 8'd5);
      expect_run("bt_boot", 6, 4'b1010);
      expect_run("bt_ready_edge", 1, 4'b1101);

      // Many requests: each pulse aborts the following boot
      for (int p = 0; p < 245; p++) begin
         req_level = 1'b0;
         @(negedge clk);
         req_level = 1'b1;
         repeat (5) @(negedge clk);
      end
      chk("sat_250", reset_count, 8'd250);
      for (int p = 0; p < 55; p++) begin
         req_level = 1'b0;
         @(negedge clk);
         req_level = 1'b1;
         repeat (5) @(negedge clk);
      end
      chk("sat_255", reset_count, 8'd255);

      // System reset mid-BOOT
      expect_run("pre_rst_boot", 3, 4'b1010);
      reset_n = 1'b0;
      #1;
      chk("rb_async_out", {4'b0, wifi_rst_n, wifi_ready, busy, boot_done}, 8'b0010);
      chk("rb_async_count", reset_count, 8'd0);
      @(negedge clk);
      chk("rb_held_out", {4'b0, wifi_rst_n, wifi_ready, busy, boot_done}, 8'b0010);
      reset_n = 1'b1;

      // System reset mid-HOLD, then a full sequence
      expect_run("rh_hold_a", 2, 4'b0010);
      reset_n = 1'b0;
      #1;
      chk("rh_async_out", {4'b0, wifi_rst_n, wifi_ready, busy, boot_done}, 8'b0010);
      @(negedge clk);
      reset_n = 1'b1;
      expect_run("rh_hold", 3, 4'b0010);
      expect_run("rh_boot", 6, 4'b1010);
      expect_run("rh_ready_edge", 1, 4'b1101);
      expect_run("rh_ready", 1, 4'b1100);
      chk("rh_count", reset_count, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
